axi_reg_arbiter: RTL and testbench

Two-master arbiter for the simple register interface that the AXI-Lite slave front-end exports (address, ingress rdy/ack strobe, egress req/rdy strobe, invalid-address flag). It lets two register-interface masters, e.g. the AXI-Lite slave and a debug command port, share one downstream register bank. Only one transaction is outstanding at a time. It sits between the masters' register interfaces and the user register decode logic.

---
 rtl/axi_reg_arb_pkg.sv | 17 +
 rtl/reg_arb_rr_picker.sv | 34 +++
 rtl/axi_reg_arbiter.sv | 156 +++++++++++++++
 tb/tb_axi_reg_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_reg_arb_pkg.sv
// Shared types and constants for the two-master register-interface arbiter.
package axi_reg_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DONE  = 3'd3,
        ST_COOL  = 3'd4
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/reg_arb_rr_picker.sv
// Two-way round-robin picker: combinational grant, registered last_grant.
module reg_arb_rr_picker
    import axi_reg_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       grant,
    output logic       valid
);

    logic last_grant;

    always_comb begin
        valid = |req;
        grant = M0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = M1;
        end
    end

    // Resets to M1 so that m0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= M1;
        end else if (take && valid) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/axi_reg_arbiter.sv
// Two-master register-interface arbiter, one transaction outstanding at a time.
// Optional downstream timeout is built when REG_ARB_TIMEOUT_EN is defined.
module axi_reg_arbiter
    import axi_reg_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_m0_reg_address,
    input  logic                  i_m0_reg_in_rdy,
    input  logic [DATA_WIDTH-1:0] i_m0_reg_in_data,
    output logic                  o_m0_reg_in_ack_stb,
    input  logic                  i_m0_reg_out_req,
    output logic                  o_m0_reg_out_rdy_stb,
    output logic [DATA_WIDTH-1:0] o_m0_reg_out_data,
    output logic                  o_m0_reg_invalid_addr,
    input  logic [ADDR_WIDTH-1:0] i_m1_reg_address,
    input  logic                  i_m1_reg_in_rdy,
    input  logic [DATA_WIDTH-1:0] i_m1_reg_in_data,
    output logic                  o_m1_reg_in_ack_stb,
    input  logic                  i_m1_reg_out_req,
    output logic                  o_m1_reg_out_rdy_stb,
    output logic [DATA_WIDTH-1:0] o_m1_reg_out_data,
    output logic                  o_m1_reg_invalid_addr,
    output logic [ADDR_WIDTH-1:0] o_reg_address,
    output logic                  o_reg_in_rdy,
    output logic [DATA_WIDTH-1:0] o_reg_in_data,
    input  logic                  i_reg_in_ack_stb,
    output logic                  o_reg_out_req,
    input  logic                  i_reg_out_rdy_stb,
    input  logic [DATA_WIDTH-1:0] i_reg_out_data,
    input  logic                  i_reg_invalid_addr
);

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    arb_state_t state, state_nxt;

    logic [1:0]            req;
    logic                  pick, pick_valid, pick_wr;
    logic                  grant_q, wr_q, inv_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata0_q, rdata1_q, rdata_nxt;
    logic                  timeout, wr_done, rd_done, done;

    assign req     = {i_m1_reg_in_rdy | i_m1_reg_out_req, i_m0_reg_in_rdy | i_m0_reg_out_req};
    assign pick_wr = (pick == M1) ? i_m1_reg_in_rdy : i_m0_reg_in_rdy;

    reg_arb_rr_picker u_picker (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .take  (state == ST_IDLE),
        .grant (pick),
        .valid (pick_valid)
    );

`ifdef REG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt;

    // Cleared throughout IDLE, so it is zero on the first WRITE/READ cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ST_WRITE || state == ST_READ) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    assign wr_done   = (state == ST_WRITE) && (i_reg_in_ack_stb || timeout);
    assign rd_done   = (state == ST_READ) && (i_reg_out_rdy_stb || timeout);
    assign done      = wr_done || rd_done;
    assign rdata_nxt = i_reg_out_rdy_stb ? i_reg_out_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_valid) state_nxt = pick_wr ? ST_WRITE : ST_READ;
            ST_WRITE: if (done) state_nxt = ST_DONE;
            ST_READ:  if (done) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_COOL;
            ST_COOL:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q  <= M0;
            wr_q     <= 1'b0;
            inv_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (state == ST_IDLE && pick_valid) begin
                grant_q <= pick;
                wr_q    <= pick_wr;
                addr_q  <= (pick == M1) ? i_m1_reg_address : i_m0_reg_address;
                wdata_q <= (pick == M1) ? i_m1_reg_in_data : i_m0_reg_in_data;
            end
            if (wr_done) begin
                inv_q <= i_reg_in_ack_stb ? i_reg_invalid_addr : 1'b1;
            end
            // Read data only lands in the served master's register; the other keeps its last value.
            if (rd_done) begin
                inv_q <= i_reg_out_rdy_stb ? i_reg_invalid_addr : 1'b1;
                if (grant_q == M1) begin
                    rdata1_q <= rdata_nxt;
                end else begin
                    rdata0_q <= rdata_nxt;
                end
            end
        end
    end

    always_comb begin
        o_reg_in_rdy          = (state == ST_WRITE);
        o_reg_out_req         = (state == ST_READ);
        o_reg_address         = addr_q;
        o_reg_in_data         = wdata_q;
        o_m0_reg_in_ack_stb   = (state == ST_DONE) && (grant_q == M0) && wr_q;
        o_m0_reg_out_rdy_stb  = (state == ST_DONE) && (grant_q == M0) && !wr_q;
        o_m0_reg_invalid_addr = (state == ST_DONE) && (grant_q == M0) && inv_q;
        o_m1_reg_in_ack_stb   = (state == ST_DONE) && (grant_q == M1) && wr_q;
        o_m1_reg_out_rdy_stb  = (state == ST_DONE) && (grant_q == M1) && !wr_q;
        o_m1_reg_invalid_addr = (state == ST_DONE) && (grant_q == M1) && inv_q;
        o_m0_reg_out_data     = rdata0_q;
        o_m1_reg_out_data     = rdata1_q;
    end

endmodule

// File: tb/tb_axi_reg_arbiter.sv
// Scoreboard bench for axi_reg_arbiter; the timeout case runs when REG_ARB_TIMEOUT_EN is defined.
module tb_axi_reg_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] i_m0_reg_address, i_m1_reg_address;
    logic          i_m0_reg_in_rdy, i_m1_reg_in_rdy;
    logic [DW-1:0] i_m0_reg_in_data, i_m1_reg_in_data;
    logic          i_m0_reg_out_req, i_m1_reg_out_req;
    logic          o_m0_reg_in_ack_stb, o_m1_reg_in_ack_stb;
    logic          o_m0_reg_out_rdy_stb, o_m1_reg_out_rdy_stb;
    logic [DW-1:0] o_m0_reg_out_data, o_m1_reg_out_data;
    logic          o_m0_reg_invalid_addr, o_m1_reg_invalid_addr;
    logic [AW-1:0] o_reg_address;
    logic          o_reg_in_rdy, o_reg_out_req;
    logic [DW-1:0] o_reg_in_data;
    logic          i_reg_in_ack_stb = 1'b0;
    logic          i_reg_out_rdy_stb = 1'b0;
    logic [DW-1:0] i_reg_out_data = '0;
    logic          i_reg_invalid_addr = 1'b0;

    always #5 clk = ~clk;

    axi_reg_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_m0_reg_address      (i_m0_reg_address),
        .i_m0_reg_in_rdy       (i_m0_reg_in_rdy),
        .i_m0_reg_in_data      (i_m0_reg_in_data),
        .o_m0_reg_in_ack_stb   (o_m0_reg_in_ack_stb),
        .i_m0_reg_out_req      (i_m0_reg_out_req),
        .o_m0_reg_out_rdy_stb  (o_m0_reg_out_rdy_stb),
        .o_m0_reg_out_data     (o_m0_reg_out_data),
        .o_m0_reg_invalid_addr (o_m0_reg_invalid_addr),
        .i_m1_reg_address      (i_m1_reg_address),
        .i_m1_reg_in_rdy       (i_m1_reg_in_rdy),
        .i_m1_reg_in_data      (i_m1_reg_in_data),
        .o_m1_reg_in_ack_stb   (o_m1_reg_in_ack_stb),
        .i_m1_reg_out_req      (i_m1_reg_out_req),
        .o_m1_reg_out_rdy_stb  (o_m1_reg_out_rdy_stb),
        .o_m1_reg_out_data     (o_m1_reg_out_data),
        .o_m1_reg_invalid_addr (o_m1_reg_invalid_addr),
        .o_reg_address         (o_reg_address),
        .o_reg_in_rdy          (o_reg_in_rdy),
        .o_reg_in_data         (o_reg_in_data),
        .i_reg_in_ack_stb      (i_reg_in_ack_stb),
        .o_reg_out_req         (o_reg_out_req),
        .i_reg_out_rdy_stb     (i_reg_out_rdy_stb),
        .i_reg_out_data        (i_reg_out_data),
        .i_reg_invalid_addr    (i_reg_invalid_addr)
    );

    typedef struct {
        logic        m;
        logic        wr;
        logic        inv;
        logic [31:0] data;
        logic        tmo;
    } mexp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } dexp_t;

    mexp_t mq[$];
    dexp_t dq[$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   stall_seen = 0;
    logic zero_chk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream register bank model: strobes ds_delay cycles after a request rises.
    logic ds_en = 1'b1;
    int   ds_delay = 0;
    logic ds_inv = 1'b0;
    int   ds_cnt = 0;
    int   ds_strobe_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            i_reg_in_ack_stb   = 1'b0;
            i_reg_out_rdy_stb  = 1'b0;
            i_reg_invalid_addr = 1'b0;
            ds_cnt             = 0;
        end else if (i_reg_in_ack_stb || i_reg_out_rdy_stb) begin
            i_reg_in_ack_stb   = 1'b0;
            i_reg_out_rdy_stb  = 1'b0;
            i_reg_invalid_addr = 1'b0;
            ds_cnt             = 0;
        end else if ((o_reg_in_rdy || o_reg_out_req) && ds_en) begin
            if (ds_cnt == ds_delay) begin
                i_reg_in_ack_stb   = o_reg_in_rdy;
                i_reg_out_rdy_stb  = o_reg_out_req;
                i_reg_invalid_addr = ds_inv;
                i_reg_out_data     = 32'h1234_0000 | {16'h0, o_reg_address[15:0]};
                ds_strobe_cyc      = cyc;
                ds_cnt             = 0;
            end else begin
                ds_cnt = ds_cnt + 1;
            end
        end else begin
            ds_cnt = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic        all_or;
    logic        prev_req = 1'b0;
    int          req_rise_cyc = 0;
    logic [1:0]  own_s;
    logic        own_inv;
    logic [31:0] own_data;
    logic [2:0]  oth;
    mexp_t       me;
    dexp_t       de;

    assign all_or = |{o_m0_reg_in_ack_stb, o_m0_reg_out_rdy_stb, o_m0_reg_out_data, o_m0_reg_invalid_addr,
                      o_m1_reg_in_ack_stb, o_m1_reg_out_rdy_stb, o_m1_reg_out_data, o_m1_reg_invalid_addr,
                      o_reg_address, o_reg_in_rdy, o_reg_in_data, o_reg_out_req};

    // Monitor: checks downstream requests as they rise and master strobes as they appear.
    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
            if (zero_chk) chk("reset_outputs_zero", {31'b0, all_or}, 32'h0);
        end else begin
            if (stall_cnt != stall_seen) begin
                chk("wait_bound_expired", stall_cnt, stall_seen);
                stall_seen = stall_cnt;
            end
            if ((o_reg_in_rdy || o_reg_out_req) && !prev_req) begin
                req_rise_cyc = cyc;
                if (dq.size() == 0) begin
                    chk("unexpected_ds_req", 32'h1, 32'h0);
                end else begin
                    de = dq.pop_front();
                    chk("ds_kind", {30'b0, o_reg_in_rdy, o_reg_out_req}, de.wr ? 32'h2 : 32'h1);
                    chk("ds_addr", o_reg_address, de.addr);
                    if (de.wr) chk("ds_wdata", o_reg_in_data, de.data);
                end
            end
            prev_req = o_reg_in_rdy || o_reg_out_req;

            if (|{o_m0_reg_in_ack_stb, o_m0_reg_out_rdy_stb, o_m0_reg_invalid_addr,
                  o_m1_reg_in_ack_stb, o_m1_reg_out_rdy_stb, o_m1_reg_invalid_addr}) begin
                if (mq.size() == 0) begin
                    chk("unexpected_master_strobe", 32'h1, 32'h0);
                end else begin
                    me       = mq.pop_front();
                    own_s    = me.m ? {o_m1_reg_in_ack_stb, o_m1_reg_out_rdy_stb}
                                    : {o_m0_reg_in_ack_stb, o_m0_reg_out_rdy_stb};
                    own_inv  = me.m ? o_m1_reg_invalid_addr : o_m0_reg_invalid_addr;
                    own_data = me.m ? o_m1_reg_out_data : o_m0_reg_out_data;
                    oth      = me.m ? {o_m0_reg_in_ack_stb, o_m0_reg_out_rdy_stb, o_m0_reg_invalid_addr}
                                    : {o_m1_reg_in_ack_stb, o_m1_reg_out_rdy_stb, o_m1_reg_invalid_addr};
                    chk(me.m ? "m1_strobe_kind" : "m0_strobe_kind", {30'b0, own_s}, me.wr ? 32'h2 : 32'h1);
                    chk("other_master_silent", {29'b0, oth}, 32'h0);
                    chk("master_invalid_addr", {31'b0, own_inv}, {31'b0, me.inv});
                    chk("master_out_data", own_data, me.data);
                    chk("ds_req_dropped", {30'b0, o_reg_in_rdy, o_reg_out_req}, 32'h0);
                    chk("master_strobe_cycle", cyc, me.tmo ? req_rise_cyc + TMO : ds_strobe_cyc + 1);
                end
            end
        end
    end

    task automatic push_m(input logic m, input logic wr, input logic inv, input logic [31:0] data,
                          input logic tmo);
        mexp_t e;
        e.m = m; e.wr = wr; e.inv = inv; e.data = data; e.tmo = tmo;
        mq.push_back(e);
    endtask

    task automatic push_d(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        dexp_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        dq.push_back(e);
    endtask

    // Masters drop each level request on the strobe that completes it.
    task automatic tick();
        @(negedge clk);
        if (o_m0_reg_in_ack_stb)  i_m0_reg_in_rdy  = 1'b0;
        if (o_m0_reg_out_rdy_stb) i_m0_reg_out_req = 1'b0;
        if (o_m1_reg_in_ack_stb)  i_m1_reg_in_rdy  = 1'b0;
        if (o_m1_reg_out_rdy_stb) i_m1_reg_out_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (mq.size() == 0 && dq.size() == 0 &&
                !(i_m0_reg_in_rdy || i_m0_reg_out_req || i_m1_reg_in_rdy || i_m1_reg_out_req)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) stall_cnt = stall_cnt + 1;
        tick();
    endtask

    task automatic m0_req(input logic [31:0] addr, input logic [31:0] data, input logic wr, input logic rd);
        i_m0_reg_address = addr; i_m0_reg_in_data = data;
        i_m0_reg_in_rdy = wr; i_m0_reg_out_req = rd;
    endtask

    task automatic m1_req(input logic [31:0] addr, input logic [31:0] data, input logic wr, input logic rd);
        i_m1_reg_address = addr; i_m1_reg_in_data = data;
        i_m1_reg_in_rdy = wr; i_m1_reg_out_req = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1);
    end

    initial begin
        m0_req(32'h0, 32'h0, 1'b0, 1'b0);
        m1_req(32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        zero_chk = 1'b1;
        repeat (3) tick();
        zero_chk = 1'b0;
        rst = 1'b0;
        tick();

        // Tie between two reads: m0 first after reset, then m1.
        ds_delay = 1;
        push_d(1'b0, 32'h10, 32'h0); push_d(1'b0, 32'h14, 32'h0);
        push_m(1'b0, 1'b0, 1'b0, 32'h1234_0010, 1'b0);
        push_m(1'b1, 1'b0, 1'b0, 32'h1234_0014, 1'b0);
        m0_req(32'h10, 32'h0, 1'b0, 1'b1);
        m1_req(32'h14, 32'h0, 1'b0, 1'b1);
        wait_idle();

        ds_delay = 0;
        push_d(1'b0, 32'h20, 32'h0); push_d(1'b0, 32'h24, 32'h0);
        push_m(1'b0, 1'b0, 1'b0, 32'h1234_0020, 1'b0);
        push_m(1'b1, 1'b0, 1'b0, 32'h1234_0024, 1'b0);
        m0_req(32'h20, 32'h0, 1'b0, 1'b1);
        m1_req(32'h24, 32'h0, 1'b0, 1'b1);
        wait_idle();

        // m0 write with a two-cycle downstream; read data register holds.
        ds_delay = 2;
        push_d(1'b1, 32'h0, 32'hDEAD_BEEF);
        push_m(1'b0, 1'b1, 1'b0, 32'h1234_0020, 1'b0);
        m0_req(32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        wait_idle();

        // m1 write flagged invalid by the downstream.
        ds_delay = 0;
        ds_inv = 1'b1;
        push_d(1'b1, 32'h8, 32'h55AA_55AA);
        push_m(1'b1, 1'b1, 1'b1, 32'h1234_0024, 1'b0);
        m1_req(32'h8, 32'h55AA_55AA, 1'b1, 1'b0);
        wait_idle();
        ds_inv = 1'b0;

        // m0 write and read together: write first, read after cool-down.
        ds_delay = 1;
        push_d(1'b1, 32'h30, 32'hCAFE_F00D); push_d(1'b0, 32'h30, 32'h0);
        push_m(1'b0, 1'b1, 1'b0, 32'h1234_0020, 1'b0);
        push_m(1'b0, 1'b0, 1'b0, 32'h1234_0030, 1'b0);
        m0_req(32'h30, 32'hCAFE_F00D, 1'b1, 1'b1);
        wait_idle();

        // Reset while a read is outstanding; no strobe may follow and m0 wins the next tie.
        ds_en = 1'b0;
        push_d(1'b0, 32'h40, 32'h0);
        m0_req(32'h40, 32'h0, 1'b0, 1'b1);
        repeat (5) tick();
        @(posedge clk);
        #1;
        rst = 1'b1;
        zero_chk = 1'b1;
        i_m0_reg_out_req = 1'b0;
        tick();
        tick();
        zero_chk = 1'b0;
        rst = 1'b0;
        ds_en = 1'b1;
        ds_delay = 0;
        repeat (8) tick();

        push_d(1'b0, 32'h50, 32'h0); push_d(1'b0, 32'h54, 32'h0);
        push_m(1'b0, 1'b0, 1'b0, 32'h1234_0050, 1'b0);
        push_m(1'b1, 1'b0, 1'b0, 32'h1234_0054, 1'b0);
        m0_req(32'h50, 32'h0, 1'b0, 1'b1);
        m1_req(32'h54, 32'h0, 1'b0, 1'b1);
        wait_idle();

`ifdef REG_ARB_TIMEOUT_EN
        // Silent downstream: read times out with invalid flag and zero data.
        ds_en = 1'b0;
        push_d(1'b0, 32'h70, 32'h0);
        push_m(1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
        m1_req(32'h70, 32'h0, 1'b0, 1'b1);
        wait_idle();
        ds_en = 1'b1;
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
